ram_reader: RTL
===============

RAM_READER -- requirements
Module: ram_reader

Interface
REQ-001 SHALL have parameter DATA_DEPTH, default 256: number of RAM words addressed.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: RAM word width in bits.
REQ-003 SHALL have parameter BUF_DEPTH, default 3: response buffer entries; legal range 2..8.
REQ-004 SHALL derive localparam ADDR_WIDTH = $clog2(DATA_DEPTH).
REQ-005 SHALL have port clk, input, 1 bit: single clock; every register is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port req_valid_i, input, 1 bit: read request valid.
REQ-008 SHALL have port req_ready_o, output, 1 bit: read request accepted when high with req_valid_i.
REQ-009 SHALL have port req_addr_i, input, ADDR_WIDTH bits: read address.
REQ-010 SHALL have port rsp_valid_o, output, 1 bit: read data valid.
REQ-011 SHALL have port rsp_ready_i, input, 1 bit: consumer accepts read data.
REQ-012 SHALL have port rsp_data_o, output, DATA_WIDTH bits: read data.
REQ-013 SHALL have port flush_i, input, 1 bit: discard all buffered and in-flight reads.
REQ-014 SHALL have port ram_en_o, output, 1 bit: drives the read-port enable of the simple dual-port RAM.
REQ-015 SHALL have port ram_addr_o, output, ADDR_WIDTH bits: drives the read-port address.
REQ-016 SHALL have port ram_data_i, input, DATA_WIDTH bits: RAM read data with fixed 1-cycle latency after ram_en_o.

Function
REQ-017 SHALL define a request as accepted (issue) in a cycle when req_valid_i && req_ready_o.
REQ-018 SHALL drive ram_en_o = issue and ram_addr_o = req_addr_i, both combinationally.
REQ-019 SHALL register a 1-bit inflight flag, set in the cycle after an issue and clear otherwise.
REQ-020 SHALL write ram_data_i into the response FIFO in the cycle inflight is 1, unless flush_i is high.
REQ-021 SHALL compute req_ready_o = rst_n && !flush_i && (count + inflight < BUF_DEPTH), where count is the FIFO occupancy register.
REQ-022 SHALL have no combinational path from rsp_ready_i to req_ready_o.
REQ-023 SHALL drive rsp_valid_o = (count != 0) and rsp_data_o = FIFO head, both from registers only.
REQ-024 SHALL pop the FIFO head when rsp_valid_o && rsp_ready_i.
REQ-025 SHALL return responses strictly in request order.
REQ-026 SHALL hold rsp_data_o and rsp_valid_o stable while rsp_valid_o && !rsp_ready_i.
REQ-027 SHALL give a minimum request-to-response latency of 2 cycles: issue in cycle t, rsp_valid_o in cycle t+2.
REQ-028 SHALL sustain 1 request and 1 response per cycle when BUF_DEPTH >= 3 and rsp_ready_i is held high.
REQ-029 SHALL, on a simultaneous push and pop, leave count unchanged and keep both pointers correct.
REQ-030 SHALL wrap the FIFO read/write pointers modulo BUF_DEPTH; the count register SHALL be $clog2(BUF_DEPTH+1) bits wide.
REQ-031 SHALL never push when count == BUF_DEPTH; REQ-021 guarantees this.
REQ-032 SHALL, when flush_i is 1, set count to 0 and both pointers to 0 at the next edge, drop inflight data and block issue in that cycle.
REQ-033 SHALL give flush_i priority over a simultaneous push and pop.

Reset
REQ-034 SHALL, while rst_n is 0, hold req_ready_o = 0 and ram_en_o = 0.
REQ-035 SHALL, at the first edge with rst_n = 0, clear count, pointers, inflight, rsp_valid_o and rsp_data_o to 0.
REQ-036 SHALL, on reset mid-operation, discard in-flight and buffered data; no response appears after rst_n rises.
REQ-037 SHALL leave FIFO storage contents unreset; only rsp_data_o is forced to 0.

Verification
REQ-038 Single read: RAM[5] = 0xDEADBEEF, request addr 5 in cycle 0 with rsp_ready_i = 1 -> ram_en_o = 1 and ram_addr_o = 5 in cycle 0; rsp_valid_o = 1 and rsp_data_o = 0xDEADBEEF in cycle 2 only.
REQ-039 Streaming: addrs 0..15 on back-to-back cycles, rsp_ready_i = 1, BUF_DEPTH = 3 -> req_ready_o stays 1; 16 responses on consecutive cycles, in order.
REQ-040 Backpressure: rsp_ready_i = 0 and continuous requests -> exactly 3 issues; req_ready_o = 0 with count + inflight = 3; rsp_data_o holds the first word; after rsp_ready_i = 1, all words drain in order and none is lost.
REQ-041 Flush: 2 buffered words plus 1 in flight, flush_i pulsed for 1 cycle -> rsp_valid_o = 0 next cycle; the in-flight word never appears; a subsequent read of addr 7 returns RAM[7].
REQ-042 Reset mid-stream: rst_n low for 1 cycle with count = 2 and inflight = 1 -> all outputs 0 after the edge; no stale response after release.
REQ-043 Simultaneous push and pop at count = 1 -> count remains 1 and output order is preserved (checked by scoreboard).

Source files
------------

// File: rtl/ram_reader.sv
// rtl/ram_reader.sv - in-order read front end for a 1-cycle-latency RAM with a small response FIFO
module ram_reader #(
    parameter int  DATA_DEPTH = 256,
    parameter int  DATA_WIDTH = 32,
    parameter int  BUF_DEPTH  = 3,
    localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,          // single rising-edge clock
    input  logic                  rst_n,        // synchronous active-low reset
    input  logic                  req_valid_i,  // read request valid
    output logic                  req_ready_o,  // read request accepted with req_valid_i
    input  logic [ADDR_WIDTH-1:0] req_addr_i,   // read address
    output logic                  rsp_valid_o,  // read data valid
    input  logic                  rsp_ready_i,  // consumer accepts read data
    output logic [DATA_WIDTH-1:0] rsp_data_o,   // read data, registered FIFO head
    input  logic                  flush_i,      // drop buffered and in-flight reads
    output logic                  ram_en_o,     // RAM read-port enable
    output logic [ADDR_WIDTH-1:0] ram_addr_o,   // RAM read-port address
    input  logic [DATA_WIDTH-1:0] ram_data_i    // RAM read data, one cycle after ram_en_o
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr_nxt;
    logic [PTR_W-1:0]      wr_ptr_nxt;
    logic                  inflight;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [OCC_W-1:0]      occupancy;
    logic [DATA_WIDTH-1:0] head_nxt;

    // Slots already promised: stored words plus the one returning from the RAM.
    // Only registers feed this, so rsp_ready_i never reaches req_ready_o.
    assign occupancy   = {1'b0, count} + OCC_W'(inflight);
    assign req_ready_o = rst_n && !flush_i && (occupancy < OCC_W'(BUF_DEPTH));

    assign issue       = req_valid_i && req_ready_o;
    assign ram_en_o    = issue;
    assign ram_addr_o  = req_addr_i;

    assign push        = inflight && !flush_i;
    assign rsp_valid_o = (count != '0);
    assign pop         = rsp_valid_o && rsp_ready_i;

    assign rd_ptr_nxt  = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
    assign wr_ptr_nxt  = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);

    // rsp_data_o is a dedicated register so it can be cleared by reset while
    // the storage array stays unreset. It always holds the entry at rd_ptr.
    always_comb begin
        head_nxt = rsp_data_o;
        if (pop) begin
            // Popping the last stored word: the new head is the word being
            // pushed this cycle, if any; otherwise the FIFO empties and the
            // value is never presented as valid.
            if (count == CNT_W'(1)) begin
                head_nxt = ram_data_i;
            end else begin
                head_nxt = mem[rd_ptr_nxt];
            end
        end else if (push && count == '0) begin
            head_nxt = ram_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            inflight   <= 1'b0;
            rsp_data_o <= '0;
        end else begin
            inflight <= issue;
            if (flush_i) begin
                count      <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                rsp_data_o <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr_nxt;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr_nxt;
                end
                count      <= count + CNT_W'(push) - CNT_W'(pop);
                rsp_data_o <= head_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ram_data_i;
        end
    end

endmodule
